// File: rtl/rx_ipv4_parser.sv
// rx_ipv4_parser: parses and validates the IPv4 header (options included),
// publishes header fields, and forwards protocol-tagged payload bytes with
// Ethernet padding beyond Total Length stripped. Datapath is byte wide.
module rx_ipv4_parser #(
  parameter int unsigned OCT          = 8,
  parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0A02,
  parameter bit          CHECK_DST    = 1'b1,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          CHECK_CSUM   = 1'b1
) (
  input  logic           RX_CLK,
  input  logic           rst_n,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic           rx_data_valid,
  output logic [OCT-1:0] rx_data,
  output logic           rx_data_last,
  output logic           rx_data_udp,
  output logic           rx_data_icmp,
  output logic           rx_data_tcp,
  output logic           rx_hdr_valid,
  output logic [31:0]    rx_src_ip,
  output logic [31:0]    rx_dst_ip,
  output logic [7:0]     rx_protocol,
  output logic [15:0]    rx_payload_len,
  output logic           rx_err,
  output logic [2:0]     rx_err_code
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 2 * OCT;

  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_TCP  = 8'd6;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_VER   = 3'd1;
  localparam logic [2:0] ERR_IHL   = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_CSUM  = 3'd4;
  localparam logic [2:0] ERR_DST   = 3'd5;
  localparam logic [2:0] ERR_TRUNC = 3'd6;
  localparam logic [2:0] ERR_PROTO = 3'd7;

  localparam logic [CNT_W-1:0] LAST_FIXED_IDX = CNT_W'(19);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_OPT,
    S_DATA,
    S_DROP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_first;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W:0]     r_acc;
  logic [OCT-1:0]      r_hi;
  logic [3:0]          r_ver;
  logic [3:0]          r_ihl;
  logic [15:0]         r_tot_len;
  logic [7:0]          r_proto;
  logic [31:0]         r_src;
  logic [31:0]         r_dst;

  logic [WORD_W-1:0]   w_word;
  logic [WORD_W:0]     w_sum;
  logic [WORD_W-1:0]   w_fold;
  logic [CNT_W-1:0]    w_hdr_len;
  logic [15:0]         w_payload_len;
  logic                w_hdr_end;
  logic [31:0]         w_dst_full;
  logic                w_csum_ok;
  logic                w_dst_ok;
  logic                w_proto_ok;
  logic [2:0]          w_dec_code;

  logic                w_err_nxt;
  logic [2:0]          w_err_code_nxt;
  logic                w_hdr_nxt;
  logic                w_dval_nxt;
  logic                w_last_nxt;

  // Checksum word from the held even byte and the current odd byte; one's
  // complement add with the previous carry folded back in.
  assign w_word = {r_hi, rx_payload};
  assign w_sum  = {1'b0, r_acc[WORD_W-1:0]} + {{WORD_W{1'b0}}, r_acc[WORD_W]}
                + {1'b0, w_word};
  assign w_fold = w_sum[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, w_sum[WORD_W]};

  // Header geometry and the destination as it stands once byte 19 is seen.
  assign w_hdr_len     = {10'd0, r_ihl, 2'b00};
  assign w_payload_len = r_tot_len - w_hdr_len;
  assign w_hdr_end     = (r_cnt == (w_hdr_len - CNT_W'(1)));
  assign w_dst_full    = (r_cnt == LAST_FIXED_IDX) ? {r_dst[23:0], rx_payload} : r_dst;

  assign w_csum_ok  = !CHECK_CSUM || (w_fold == 16'hFFFF);
  assign w_dst_ok   = !CHECK_DST || (w_dst_full == LOCAL_IP) ||
                      (ACCEPT_BCAST && (w_dst_full == 32'hFFFF_FFFF));
  assign w_proto_ok = (r_proto == PROTO_ICMP) || (r_proto == PROTO_TCP) ||
                      (r_proto == PROTO_UDP);

  // Prioritised header verdict, meaningful on the last header byte.
  always_comb begin
    w_dec_code = ERR_NONE;
    if (r_ver != 4'd4) begin
      w_dec_code = ERR_VER;
    end else if (r_ihl < 4'd5) begin
      w_dec_code = ERR_IHL;
    end else if (r_tot_len < w_hdr_len) begin
      w_dec_code = ERR_LEN;
    end else if (!w_csum_ok) begin
      w_dec_code = ERR_CSUM;
    end else if (!w_dst_ok) begin
      w_dec_code = ERR_DST;
    end else if (!w_proto_ok) begin
      w_dec_code = ERR_PROTO;
    end
  end

  // State register.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next-cycle pulse/valid values.
  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    w_hdr_nxt      = 1'b0;
    w_dval_nxt     = 1'b0;
    w_last_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_payload_ipv4) begin
          if (r_first) begin
            w_state_nxt = S_DROP;
          end else if (rx_payload[3:0] < 4'd5) begin
            w_state_nxt    = S_DROP;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_IHL;
          end else begin
            w_state_nxt = S_HDR;
          end
        end
      end
      S_HDR, S_OPT: begin
        if (!rx_payload_ipv4) begin
          w_state_nxt    = S_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TRUNC;
        end else if (w_hdr_end) begin
          if (w_dec_code != ERR_NONE) begin
            w_state_nxt    = S_DROP;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = w_dec_code;
          end else begin
            w_hdr_nxt   = 1'b1;
            w_state_nxt = (w_payload_len == 16'd0) ? S_DROP : S_DATA;
          end
        end else if ((r_state == S_HDR) && (r_cnt == LAST_FIXED_IDX)) begin
          w_state_nxt = S_OPT;
        end
      end
      S_DATA: begin
        if (!rx_payload_ipv4) begin
          w_state_nxt    = S_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TRUNC;
        end else begin
          w_dval_nxt = 1'b1;
          if (r_cnt == (r_tot_len - 16'd1)) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (!rx_payload_ipv4) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte counter, checksum accumulator and header field capture.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      r_first   <= 1'b1;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_ver     <= '0;
      r_ihl     <= '0;
      r_tot_len <= '0;
      r_proto   <= '0;
      r_src     <= '0;
      r_dst     <= '0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          r_hi  <= rx_payload;
          if (rx_payload_ipv4) begin
            r_cnt <= CNT_W'(1);
            r_ver <= rx_payload[7:4];
            r_ihl <= rx_payload[3:0];
          end else begin
            r_cnt <= '0;
          end
        end
        S_HDR, S_OPT: begin
          if (rx_payload_ipv4) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt[0]) begin
              r_acc <= w_sum;
            end else begin
              r_hi <= rx_payload;
            end
            if (r_state == S_HDR) begin
              case (r_cnt)
                16'd2:                    r_tot_len[15:8] <= rx_payload;
                16'd3:                    r_tot_len[7:0]  <= rx_payload;
                16'd9:                    r_proto         <= rx_payload;
                16'd12, 16'd13, 16'd14,
                16'd15:                   r_src <= {r_src[23:0], rx_payload};
                16'd16, 16'd17, 16'd18,
                16'd19:                   r_dst <= {r_dst[23:0], rx_payload};
                default: ;
              endcase
            end
          end
        end
        S_DATA: begin
          if (rx_payload_ipv4) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: pulses, payload stream, held header fields and tags.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      rx_data_valid  <= 1'b0;
      rx_data        <= '0;
      rx_data_last   <= 1'b0;
      rx_data_udp    <= 1'b0;
      rx_data_icmp   <= 1'b0;
      rx_data_tcp    <= 1'b0;
      rx_hdr_valid   <= 1'b0;
      rx_src_ip      <= '0;
      rx_dst_ip      <= '0;
      rx_protocol    <= '0;
      rx_payload_len <= '0;
      rx_err         <= 1'b0;
      rx_err_code    <= '0;
    end else begin
      rx_data_valid <= w_dval_nxt;
      rx_data       <= w_dval_nxt ? rx_payload : '0;
      rx_data_last  <= w_last_nxt;
      rx_hdr_valid  <= w_hdr_nxt;
      rx_err        <= w_err_nxt;
      rx_err_code   <= w_err_code_nxt;
      if (w_hdr_nxt) begin
        rx_src_ip      <= r_src;
        rx_dst_ip      <= w_dst_full;
        rx_protocol    <= r_proto;
        rx_payload_len <= w_payload_len;
        rx_data_udp    <= (r_proto == PROTO_UDP);
        rx_data_icmp   <= (r_proto == PROTO_ICMP);
        rx_data_tcp    <= (r_proto == PROTO_TCP);
      end
    end
  end

endmodule

// File: tb/tb_rx_ipv4_parser.sv
// tb_rx_ipv4_parser: directed frames; expected events are queued as bytes are
// driven and a monitor pops and compares them whenever the parser emits.
module tb_rx_ipv4_parser;

  logic        RX_CLK;
  logic        rst_n;
  logic        rx_payload_ipv4;
  logic [7:0]  rx_payload;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_data_last;
  logic        rx_data_udp;
  logic        rx_data_icmp;
  logic        rx_data_tcp;
  logic        rx_hdr_valid;
  logic [31:0] rx_src_ip;
  logic [31:0] rx_dst_ip;
  logic [7:0]  rx_protocol;
  logic [15:0] rx_payload_len;
  logic        rx_err;
  logic [2:0]  rx_err_code;

  localparam logic [31:0] SRC   = 32'hC0A8_0A01;
  localparam logic [31:0] LOCAL = 32'hC0A8_0A02;
  localparam logic [2:0]  T_UDP  = 3'b100;
  localparam logic [2:0]  T_ICMP = 3'b010;
  localparam logic [2:0]  T_TCP  = 3'b001;

  rx_ipv4_parser dut (
    .RX_CLK         (RX_CLK),
    .rst_n          (rst_n),
    .rx_payload_ipv4(rx_payload_ipv4),
    .rx_payload     (rx_payload),
    .rx_data_valid  (rx_data_valid),
    .rx_data        (rx_data),
    .rx_data_last   (rx_data_last),
    .rx_data_udp    (rx_data_udp),
    .rx_data_icmp   (rx_data_icmp),
    .rx_data_tcp    (rx_data_tcp),
    .rx_hdr_valid   (rx_hdr_valid),
    .rx_src_ip      (rx_src_ip),
    .rx_dst_ip      (rx_dst_ip),
    .rx_protocol    (rx_protocol),
    .rx_payload_len (rx_payload_len),
    .rx_err         (rx_err),
    .rx_err_code    (rx_err_code)
  );

  initial RX_CLK = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic last; logic [2:0] tag; int stamp; } dexp_t;
  typedef struct { logic [31:0] src; logic [31:0] dst; logic [7:0] proto;
                   logic [15:0] len; int stamp; } hexp_t;
  typedef struct { logic [2:0] code; int stamp; } eexp_t;

  dexp_t dq[$];
  hexp_t hq[$];
  eexp_t eq[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [0:127];

  int         p_hdr_at, p_err_at, p_dlo, p_dhi, p_last_at;
  logic [2:0] p_code, p_tag;
  hexp_t      p_hdr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s emitted with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every emitted event against the head of its queue.
  initial begin
    dexp_t d;
    hexp_t h;
    eexp_t e;
    forever begin
      @(posedge RX_CLK);
      #2;
      if (rx_data_valid) begin
        if (dq.size() == 0) unexpected("rx_data_valid");
        else begin
          d = dq.pop_front();
          chk("rx_data", 32'(rx_data), 32'(d.data));
          chk("rx_data_last", 32'(rx_data_last), 32'(d.last));
          chk("data_tag", 32'({rx_data_udp, rx_data_icmp, rx_data_tcp}), 32'(d.tag));
          chk("data_cycle", 32'(cyc), 32'(d.stamp));
        end
      end else if (rx_data_last) begin
        unexpected("rx_data_last_without_valid");
      end
      if (rx_hdr_valid) begin
        if (hq.size() == 0) unexpected("rx_hdr_valid");
        else begin
          h = hq.pop_front();
          chk("rx_src_ip", rx_src_ip, h.src);
          chk("rx_dst_ip", rx_dst_ip, h.dst);
          chk("rx_protocol", 32'(rx_protocol), 32'(h.proto));
          chk("rx_payload_len", 32'(rx_payload_len), 32'(h.len));
          chk("hdr_cycle", 32'(cyc), 32'(h.stamp));
        end
      end
      if (rx_err) begin
        if (eq.size() == 0) unexpected("rx_err");
        else begin
          e = eq.pop_front();
          chk("rx_err_code", 32'(rx_err_code), 32'(e.code));
          chk("err_cycle", 32'(cyc), 32'(e.stamp));
        end
      end
    end
  end

  function automatic logic [15:0] calc_cs(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i += 2) s = s + 32'({frame[i], frame[i+1]});
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  task automatic build(input logic [7:0] vi, input logic [15:0] tot,
                       input logic [7:0] proto, input logic [31:0] dst);
    int hl;
    hl = 4 * int'(vi[3:0]);
    for (int i = 0; i < 128; i++) frame[i] = 8'h00;
    frame[0] = vi;
    frame[2] = tot[15:8];
    frame[3] = tot[7:0];
    frame[8] = 8'h40;
    frame[9] = proto;
    {frame[12], frame[13], frame[14], frame[15]} = SRC;
    {frame[16], frame[17], frame[18], frame[19]} = dst;
    for (int i = 20; i < hl; i++) frame[i] = 8'(i - 19);
    {frame[10], frame[11]} = calc_cs(hl);
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] base);
    for (int i = lo; i <= hi; i++) frame[i] = 8'(base + 8'(i - lo));
  endtask

  task automatic plan_clear();
    p_hdr_at = -1; p_err_at = -1; p_dlo = -1; p_dhi = -2; p_last_at = -1;
    p_code = 3'd0; p_tag = 3'd0;
  endtask

  task automatic plan_ok(input int hdr_at, input int dlo, input int dhi, input int last_at,
                         input logic [2:0] tag, input logic [31:0] dst,
                         input logic [7:0] proto, input logic [15:0] len);
    plan_clear();
    p_hdr_at = hdr_at; p_dlo = dlo; p_dhi = dhi; p_last_at = last_at; p_tag = tag;
    p_hdr.src = SRC; p_hdr.dst = dst; p_hdr.proto = proto; p_hdr.len = len;
  endtask

  task automatic plan_err(input int at, input logic [2:0] code);
    plan_clear();
    p_err_at = at; p_code = code;
  endtask

  task automatic push(input int i);
    int    st;
    hexp_t h;
    dexp_t d;
    eexp_t e;
    st = cyc + 1;
    if (i == p_hdr_at) begin h = p_hdr; h.stamp = st; hq.push_back(h); end
    if (i == p_err_at) begin e.code = p_code; e.stamp = st; eq.push_back(e); end
    if (i >= p_dlo && i <= p_dhi) begin
      d.data = frame[i]; d.last = (i == p_last_at); d.tag = p_tag; d.stamp = st;
      dq.push_back(d);
    end
  endtask

  task automatic send(input int len, input int rst_at);
    for (int i = 0; i < len; i++) begin
      @(negedge RX_CLK);
      rx_payload_ipv4 = 1'b1;
      rx_payload      = frame[i];
      rst_n           = (i == rst_at) ? 1'b0 : 1'b1;
      push(i);
    end
    @(negedge RX_CLK);
    rx_payload_ipv4 = 1'b0;
    rx_payload      = 8'h00;
    rst_n           = 1'b1;
    push(len);
  endtask

  task automatic t1_frame(input logic [7:0] cs_hi);
    build(8'h45, 16'h0024, 8'h11, LOCAL);
    frame[10] = cs_hi;
    frame[11] = 8'h75;
    fill(20, 35, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_payload_ipv4 = 1'b0;
    rx_payload = 8'h00;
    plan_clear();
    repeat (3) @(negedge RX_CLK);
    rst_n = 1'b1;
    @(posedge RX_CLK);
    #2;
    chk("reset_data_valid", 32'(rx_data_valid), 32'd0);
    chk("reset_hdr_valid", 32'(rx_hdr_valid), 32'd0);
    chk("reset_err", 32'(rx_err), 32'd0);
    chk("reset_src_ip", rx_src_ip, 32'd0);
    chk("reset_payload_len", 32'(rx_payload_len), 32'd0);
    chk("reset_tags", 32'({rx_data_udp, rx_data_icmp, rx_data_tcp}), 32'd0);

    // UDP, IHL 5, hand-computed checksum E575, 16 payload bytes 00..0F.
    t1_frame(8'hE5);
    plan_ok(19, 20, 35, 35, T_UDP, LOCAL, 8'h11, 16'd16);
    send(36, -1);

    // Same frame, corrupted checksum byte 10.
    t1_frame(8'hE4);
    plan_err(19, 3'd4);
    send(36, -1);

    // IHL 6 with options, ICMP, 8 payload bytes starting at frame byte 24.
    build(8'h46, 16'd32, 8'h01, LOCAL);
    fill(24, 31, 8'hA0);
    plan_ok(23, 24, 31, 31, T_ICMP, LOCAL, 8'h01, 16'd8);
    send(32, -1);

    // 46-byte frame, Total Length 28: padding must be stripped.
    build(8'h45, 16'd28, 8'h11, LOCAL);
    fill(20, 27, 8'h30);
    for (int i = 28; i < 46; i++) frame[i] = 8'hEE;
    plan_ok(19, 20, 27, 27, T_UDP, LOCAL, 8'h11, 16'd8);
    send(46, -1);

    // Total Length 100 but frame ends after 40 bytes: truncation.
    build(8'h45, 16'd100, 8'h06, LOCAL);
    fill(20, 39, 8'h50);
    plan_ok(19, 20, 39, -1, T_TCP, LOCAL, 8'h06, 16'd80);
    p_err_at = 40; p_code = 3'd6;
    send(40, -1);

    // Foreign destination rejected.
    build(8'h45, 16'd28, 8'h11, 32'h0A00_0009);
    plan_err(19, 3'd5);
    send(28, -1);

    // Broadcast destination accepted.
    build(8'h45, 16'd28, 8'h11, 32'hFFFF_FFFF);
    fill(20, 27, 8'h70);
    plan_ok(19, 20, 27, 27, T_UDP, 32'hFFFF_FFFF, 8'h11, 16'd8);
    send(28, -1);

    // Version 6: reported at header end.
    build(8'h65, 16'd28, 8'h11, LOCAL);
    plan_err(19, 3'd1);
    send(28, -1);

    // IHL 4: reported on byte 0.
    build(8'h44, 16'd28, 8'h11, LOCAL);
    plan_err(0, 3'd2);
    send(28, -1);

    // Total Length shorter than the header.
    build(8'h45, 16'd16, 8'h11, LOCAL);
    plan_err(19, 3'd3);
    send(28, -1);

    // Unsupported protocol.
    build(8'h45, 16'd28, 8'h02, LOCAL);
    plan_err(19, 3'd7);
    send(28, -1);

    // Zero-length payload: header accepted, no data.
    build(8'h45, 16'd20, 8'h11, LOCAL);
    plan_ok(19, -1, -2, -1, T_UDP, LOCAL, 8'h11, 16'd0);
    send(24, -1);

    // Reset pulse at byte 5 with the frame continuing: nothing emitted.
    t1_frame(8'hE5);
    plan_clear();
    send(36, 5);
    chk("post_reset_src_ip", rx_src_ip, 32'd0);
    chk("post_reset_dst_ip", rx_dst_ip, 32'd0);
    chk("post_reset_protocol", 32'(rx_protocol), 32'd0);
    chk("post_reset_payload_len", 32'(rx_payload_len), 32'd0);

    // Next frame after a one-cycle gap parses normally.
    t1_frame(8'hE5);
    plan_ok(19, 20, 35, 35, T_UDP, LOCAL, 8'h11, 16'd16);
    send(36, -1);

    repeat (6) @(negedge RX_CLK);
    chk("pending_data", 32'(dq.size()), 32'd0);
    chk("pending_hdr", 32'(hq.size()), 32'd0);
    chk("pending_err", 32'(eq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_ipv4_parser.md
Name: rx_ipv4_parser

Overview:
Second-generation IPv4 receive parser. It consumes the byte stream handed over by the Ethernet RX block (EtherType 0x0800 already matched) and does the following:
- parses the full header, including IHL options, and validates it (version, IHL, length, header checksum, destination address);
- publishes the header fields;
- forwards only payload bytes, framed with valid/last and tagged by protocol (UDP/ICMP/TCP);
- strips Ethernet padding beyond Total Length.

Parameters:
OCT, 8, datapath byte width; only 8 is supported.
LOCAL_IP, 32'hC0A8_0A02, station IPv4 address for destination filtering.
CHECK_DST, 1, 1 = drop packets whose destination is neither LOCAL_IP nor broadcast.
ACCEPT_BCAST, 1, 1 = accept 255.255.255.255 as destination.
CHECK_CSUM, 1, 1 = drop packets with a bad header checksum.

Ports:
RX_CLK  input  1  receive clock; all logic on the rising edge.
rst_n  input  1  synchronous, active-low reset.
rx_payload_ipv4  input  1  high for each contiguous IPv4 byte of a frame; low = frame ended/idle.
rx_payload  input  OCT  byte, valid when rx_payload_ipv4 is high; network order.
rx_data_valid  output  1  payload byte valid.
rx_data  output  OCT  payload byte.
rx_data_last  output  1  marks the final payload byte (byte Total Length - 1).
rx_data_udp  output  1  protocol tag, protocol 17; constant across the packet.
rx_data_icmp  output  1  protocol tag, protocol 1.
rx_data_tcp  output  1  protocol tag, protocol 6.
rx_hdr_valid  output  1  one-cycle pulse: header accepted.
rx_src_ip  output  32  source IP; held until the next rx_hdr_valid.
rx_dst_ip  output  32  destination IP; held.
rx_protocol  output  8  protocol field; held.
rx_payload_len  output  16  Total Length - IHL*4; held.
rx_err  output  1  one-cycle pulse: packet rejected or truncated.
rx_err_code  output  3  valid with rx_err: 1 version, 2 IHL<5, 3 Total Length<IHL*4, 4 checksum, 5 destination, 6 truncated, 7 unsupported protocol.

Behaviour:
- Reset (rst_n low at an edge): state IDLE, byte counters 0, checksum accumulator 0. All pulse/valid outputs and tags 0; held fields 0.
- Resync: if rx_payload_ipv4 is high on the first cycle after reset release, go to DROP (no mid-frame start).
- States:
  - IDLE: first valid byte goes to HDR, byte count 1.
  - HDR: bytes 0..19.
  - OPT: bytes 20..IHL*4-1, ignored but included in the checksum.
  - DATA: payload bytes.
  - DROP: discard until rx_payload_ipv4 is low, then IDLE.
- Rule for every state: rx_payload_ipv4 low returns to IDLE.
- Byte counter: 16 bits, counts frame bytes from 0.
- Field capture: {version, IHL} from byte 0 (version = bits 7:4). Total Length from bytes 2-3, protocol from byte 9, source from bytes 12-15, destination from bytes 16-19.
- Checksum: even bytes form the high half of a 16-bit word. Add each word into a 17-bit accumulator with end-around carry. The header is good when the folded sum of all IHL*4 bytes = 16'hFFFF.
- Header decision, made combinationally on the cycle of the last header byte (count = IHL*4-1), in this priority order:
  1. version != 4 → code 1.
  2. IHL < 5 → code 2, evaluated at byte 0; go to DROP immediately with rx_err.
  3. Total Length < IHL*4 → code 3.
  4. checksum bad → code 4.
  5. destination mismatch → code 5.
  6. protocol not in {1, 6, 17} → code 7.
- Header decision outcome: any failure → rx_err with its code on the next cycle, go to DROP. Otherwise rx_hdr_valid on the next cycle with held fields updated, then DATA. If the payload length is 0, go to DROP instead (no data emitted).
- Version failure (code 1) is reported at header end, not at byte 0.
- DATA: each input byte appears on rx_data with rx_data_valid exactly 1 cycle later. The tag equals the decoded protocol. rx_data_last is asserted with the byte at count Total Length-1, then the state goes to DROP (padding discarded).
- Latency: first payload byte is output one cycle after rx_hdr_valid. There are no bubbles, because the input is contiguous.
- Truncation: rx_payload_ipv4 falls in HDR/OPT/DATA before completion → rx_err code 6 on the next cycle. No rx_data_last is issued; the consumer discards the partial packet.
- Back-to-back frames: rx_payload_ipv4 must drop for at least 1 cycle between frames. The IDLE entry clears the accumulator and counter.
- Reset mid-packet: abort with no rx_err and no rx_data_last.

Test Plan:
1. UDP, IHL 5: header 45 00 00 24 …, protocol 11, correct checksum, dst = LOCAL_IP, 16 payload bytes 00..0F → rx_hdr_valid once; 16 rx_data_valid with rx_data_udp=1; rx_data_last on byte 0F; rx_payload_len=16.
2. Same packet with checksum byte 10 XOR 01 → rx_err code 4 one cycle after the last header byte; zero rx_data_valid.
3. IHL 6 with 4 option bytes and 8 ICMP payload bytes, checksum covering the options → options skipped; 8 bytes with rx_data_icmp=1; first data byte = frame byte 24.
4. 46-byte frame with Total Length 28 (8 UDP bytes + 18 pad bytes) → exactly 8 outputs, last on the 8th; pad bytes never appear; no rx_err.
5. Total Length 100, frame ends after 40 bytes → 20 data bytes, then rx_err code 6; no rx_data_last. Separately, dst 10.0.0.9 with CHECK_DST=1 → code 5; dst 255.255.255.255 → accepted.
6. rst_n low for 1 cycle at payload byte 5 while rx_payload_ipv4 stays high → outputs 0, remainder dropped. The next frame after a 1-cycle gap parses correctly.
